// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder
//   WIDTH-bit adder/subtractor. The carry chain is split into CHUNK-bit
//   pieces and one piece is summed per pipeline stage, so the critical path
//   is a single CHUNK-bit add. Latency is STAGES = WIDTH/CHUNK cycles and one
//   operation can be accepted every cycle.
//
//   Handshake: a beat moves on an edge where valid && ready are both high.
//   A source holds its beat (and valid) until it is taken. The whole pipe
//   moves as one unit: it advances unless the output register holds a
//   result that downstream refuses, so in_ready is exactly that condition.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears every stage
//   in_valid   operand beat present on A/B/CIN/SUB
//   in_ready   beat is taken at the next edge if in_valid is high
//   A, B       operands
//   CIN        carry into bit 0
//   SUB        1: B is inverted before the add (with CIN=1 gives A-B)
//   out_valid  result beat present on S/COUT/OVF
//   out_ready  downstream takes the result at the next edge
//   S          sum modulo 2^WIDTH
//   COUT       carry out of bit WIDTH-1 (for A-B: 1 = no borrow)
//   OVF        signed overflow (carry into MSB xor carry out of MSB)
//
// WIDTH must be a multiple of CHUNK.

module pipelined_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  // Subtraction is folded in at the front so later stages only ever add.
  assign b_eff    = SUB ? ~B : B;

  // Stage k sums chunk k. Operands travel shifted right so the chunk a stage
  // needs is always in the low CHUNK bits; consumed chunks are dropped.
  // The partial sum grows by one chunk per stage, new chunk on top, so after
  // the last stage it is in natural bit order.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W = WIDTH - k * CHUNK;  // operand bits still to be summed
    localparam int SW   = (k + 1) * CHUNK;    // sum bits known after this stage

    logic [IN_W-1:0] a_in;
    logic [IN_W-1:0] b_in;
    logic            c_in;
    logic            v_in;
    logic [CHUNK:0]  csum;
    logic [SW-1:0]   s_next;
    logic [SW-1:0]   s_q;
    logic            c_q;
    logic            v_q;

    if (k == 0) begin : g_head
      assign a_in   = A;
      assign b_in   = b_eff;
      assign c_in   = CIN;
      assign v_in   = in_valid;
      assign s_next = csum[CHUNK-1:0];
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_next = {csum[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign csum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (advance) begin
        s_q <= s_next;
        c_q <= csum[CHUNK];
        v_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Chunks not yet summed, carried to the next stage.
      logic [IN_W-CHUNK-1:0] a_q;
      logic [IN_W-CHUNK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[IN_W-1:CHUNK];
          b_q <= b_in[IN_W-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // The carry into the MSB is recovered from the MSB sum bit:
      // s = a ^ b ^ c_in  =>  c_in = s ^ a ^ b.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= csum[CHUNK]
                 ^ (a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ csum[CHUNK-1]);
        end
      end
    end
  end

  assign S         = g_stage[STAGES-1].s_q;
  assign COUT      = g_stage[STAGES-1].c_q;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign OVF       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
